// File: rtl/npc_pkg.sv
// npc_pkg: shared writeback-stage constants and state encoding for the NPC core.
package npc_pkg;
    localparam logic [1:0] WB_SEL_MEM = 2'b00;
    localparam logic [1:0] WB_SEL_PC4 = 2'b01;
    localparam logic [1:0] WB_SEL_ALU = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;
    localparam logic [2:0] LOAD_F3_LB  = 3'b000;
    localparam logic [2:0] LOAD_F3_LH  = 3'b001;
    localparam logic [2:0] LOAD_F3_LW  = 3'b010;
    localparam logic [2:0] LOAD_F3_LBU = 3'b100;
    localparam logic [2:0] LOAD_F3_LHU = 3'b101;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_WB} state_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword lane, extends it by funct3 and
// flags illegal funct3 codes or misaligned addresses.
module load_align
    import npc_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        bad
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{addr, 3'b000} +: 8];
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];
    always_comb begin
        data = '0;
        bad  = 1'b0;
        case (funct3)
            LOAD_F3_LB:  data = {{24{b[7]}}, b};
            LOAD_F3_LBU: data = {24'd0, b};
            LOAD_F3_LH:  begin data = {{16{h[15]}}, h}; bad = addr[0]; end
            LOAD_F3_LHU: begin data = {16'd0, h}; bad = addr[0]; end
            LOAD_F3_LW:  begin data = rdata; bad = |addr; end
            default:     bad = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_load_stage.sv
// wb_load_stage: NPC writeback stage; retires one instruction per handshake and
// runs the data-memory read transaction for loads before writing the register file.
module wb_load_stage
    import npc_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_wb_sel,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_imm,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            load_err
);
    state_t          state;
    logic [TO_W-1:0] cnt;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [1:0]      lo_q;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] sel_data;
    logic            bad;

    assign in_ready = (state == ST_IDLE);
    assign sel_data = (in_wb_sel == WB_SEL_PC4) ? in_pc + XLEN'(4) :
                      (in_wb_sel == WB_SEL_ALU) ? in_alu :
                      (in_wb_sel == WB_SEL_IMM) ? in_imm : '0;

    // In IDLE the aligner checks the incoming load; afterwards it formats the returned word.
    load_align u_align (
        .rdata  (mem_rdata),
        .addr   (in_ready ? in_alu[1:0] : lo_q),
        .funct3 (in_ready ? in_funct3 : f3_q),
        .data   (ld_data),
        .bad    (bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            load_err <= 1'b0;
            cnt      <= '0;
            rd_q     <= '0;
            f3_q     <= '0;
            lo_q     <= '0;
        end else begin
            rf_we    <= 1'b0;
            load_err <= 1'b0;
            case (state)
                ST_IDLE: if (in_valid) begin
                    rd_q <= in_rd;
                    f3_q <= in_funct3;
                    lo_q <= in_alu[1:0];
                    if (in_is_load) begin
                        if (bad) load_err <= 1'b1;
                        else begin
                            state    <= ST_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= {in_alu[XLEN-1:2], 2'b00};
                        end
                    end else if (in_rd_we) begin
                        state    <= ST_WB;
                        rf_we    <= |in_rd;
                        rf_waddr <= in_rd;
                        rf_wdata <= sel_data;
                    end
                end
                ST_REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    cnt     <= '0;
                    if (mem_rvalid) begin
                        state    <= ST_WB;
                        rf_we    <= |rd_q;
                        rf_waddr <= rd_q;
                        rf_wdata <= ld_data;
                    end else state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state    <= ST_WB;
                        rf_we    <= |rd_q;
                        rf_waddr <= rd_q;
                        rf_wdata <= ld_data;
                    end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state    <= ST_IDLE;
                        load_err <= 1'b1;
                        cnt      <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                ST_WB: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_load_stage.sv
// tb_wb_load_stage: directed vectors with hand-computed results for wb_load_stage.
module tb_wb_load_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_wb_sel = '0;
    logic        in_rd_we = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_pc = '0, in_alu = '0, in_imm = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        load_err;
    int          n_checks = 0;
    int          n_fail = 0;

    wb_load_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_sel(in_wb_sel), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_rd(in_rd), .in_pc(in_pc), .in_alu(in_alu),
        .in_imm(in_imm), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one instruction at a negedge and returns at the following negedge.
    task automatic issue(input logic ld, input logic [1:0] sel, input logic we,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] imm);
        in_valid = 1'b1; in_is_load = ld; in_wb_sel = sel; in_rd_we = we;
        in_funct3 = f3; in_rd = rd; in_pc = pc; in_alu = alu; in_imm = imm;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wb_check(input string tag, input logic [4:0] rd, input logic [31:0] d);
        check({tag, "_we"}, rf_we, 1'b1);
        check({tag, "_waddr"}, rf_waddr, rd);
        check({tag, "_wdata"}, rf_wdata, d);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_wdata", rf_wdata, 32'h0);
        check("rst_load_err", load_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // addi
        check("addi_ready_before", in_ready, 1'b1);
        issue(1'b0, 2'b10, 1'b1, 3'b000, 5'd5, 32'h0, 32'h0000_1234, 32'h0);
        wb_check("addi", 5'd5, 32'h0000_1234);
        check("addi_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check("addi_ready_back", in_ready, 1'b1);
        check("addi_we_off", rf_we, 1'b0);

        // jal then lui then rd=0
        issue(1'b0, 2'b01, 1'b1, 3'b000, 5'd1, 32'h8000_0FFC, 32'h0, 32'h0);
        wb_check("jal", 5'd1, 32'h8000_1000);
        @(negedge clk);
        issue(1'b0, 2'b11, 1'b1, 3'b000, 5'd7, 32'h0, 32'h0, 32'hABCD_E000);
        wb_check("lui", 5'd7, 32'hABCD_E000);
        @(negedge clk);
        issue(1'b0, 2'b11, 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h1111_2222);
        check("rd0_we", rf_we, 1'b0);
        check("rd0_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check("rd0_ready_back", in_ready, 1'b1);

        // store-like: no write, stays ready
        issue(1'b0, 2'b10, 1'b0, 3'b010, 5'd3, 32'h0, 32'h40, 32'h0);
        check("store_we", rf_we, 1'b0);
        check("store_ready", in_ready, 1'b1);

        // lb with grant delayed three cycles
        issue(1'b1, 2'b10, 1'b1, 3'b000, 5'd3, 32'h0, 32'h8000_0003, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("lb_req_hold", mem_req, 1'b1);
            check("lb_addr_hold", mem_addr, 32'h8000_0000);
            @(negedge clk);
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_7F01;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        wb_check("lb", 5'd3, 32'hFFFF_FF80);
        check("lb_req_drop", mem_req, 1'b0);
        @(negedge clk);

        // lbu through WAIT
        issue(1'b1, 2'b01, 1'b1, 3'b100, 5'd4, 32'h0, 32'h8000_0003, 32'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("lbu_req_drop", mem_req, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_7F01;
        @(negedge clk);
        mem_rvalid = 1'b0;
        wb_check("lbu", 5'd4, 32'h0000_0080);
        @(negedge clk);

        // lh / lhu zero-wait: rf_we two cycles after accept
        issue(1'b1, 2'b10, 1'b1, 3'b001, 5'd6, 32'h0, 32'h8000_0002, 32'h0);
        check("lh_no_early_we", rf_we, 1'b0);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        wb_check("lh", 5'd6, 32'hFFFF_8001);
        @(negedge clk);
        issue(1'b1, 2'b11, 1'b1, 3'b101, 5'd8, 32'h0, 32'h8000_0002, 32'h0);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        wb_check("lhu", 5'd8, 32'h0000_8001);
        @(negedge clk);

        // misaligned lw and illegal funct3
        issue(1'b1, 2'b00, 1'b1, 3'b010, 5'd9, 32'h0, 32'h8000_0002, 32'h0);
        check("mis_err", load_err, 1'b1);
        check("mis_req", mem_req, 1'b0);
        check("mis_we", rf_we, 1'b0);
        check("mis_ready", in_ready, 1'b1);
        @(negedge clk);
        check("mis_err_pulse", load_err, 1'b0);
        check("mis_req2", mem_req, 1'b0);
        issue(1'b1, 2'b00, 1'b1, 3'b011, 5'd9, 32'h0, 32'h8000_0000, 32'h0);
        check("f3_err", load_err, 1'b1);
        check("f3_req", mem_req, 1'b0);
        @(negedge clk);
        check("f3_we", rf_we, 1'b0);
        check("f3_req2", mem_req, 1'b0);

        // timeout
        issue(1'b1, 2'b00, 1'b1, 3'b010, 5'd10, 32'h0, 32'h8000_0010, 32'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        k = 0;
        while (!load_err && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", 32'(k), 32'd255);
        check("timeout_ready", in_ready, 1'b1);
        check("timeout_we", rf_we, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid_we", rf_we, 1'b0);
        check("late_rvalid_ready", in_ready, 1'b1);

        // reset while waiting
        issue(1'b1, 2'b00, 1'b1, 3'b010, 5'd11, 32'h0, 32'h8000_0020, 32'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_wait_req", mem_req, 1'b0);
        check("rst_wait_we", rf_we, 1'b0);
        check("rst_wait_ready", in_ready, 1'b1);
        check("rst_wait_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b1, 3'b000, 5'd12, 32'h0, 32'h0000_5A5A, 32'h0);
        wb_check("post_rst", 5'd12, 32'h0000_5A5A);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
